// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared codes and FSM state type for the multi-cycle ALU control block
package alu_ctrl_pkg;

    // Operation class from the main decoder
    localparam logic [2:0] ALUOP_RTYPE = 3'd0;
    localparam logic [2:0] ALUOP_CLS1  = 3'd1;
    localparam logic [2:0] ALUOP_CLS2  = 3'd2;
    localparam logic [2:0] ALUOP_CLS3  = 3'd3;
    localparam logic [2:0] ALUOP_CLS4  = 3'd4;
    localparam logic [2:0] ALUOP_CLS5  = 3'd5;
    localparam logic [2:0] ALUOP_CLS6  = 3'd6;

    // R-type function field codes
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_SRAV  = 6'd7;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    // ALU control codes
    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_CLS4    = 4'b0011;
    localparam logic [3:0] CTRL_SLT     = 4'b0100;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_CLS1    = 4'b0111;
    localparam logic [3:0] CTRL_SRA     = 4'b1000;
    localparam logic [3:0] CTRL_SRAV    = 4'b1001;
    localparam logic [3:0] CTRL_CLS2    = 4'b1010;
    localparam logic [3:0] CTRL_CLS6    = 4'b1011;
    localparam logic [3:0] CTRL_HILO    = 4'b1100;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    // Multi-cycle sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // True for the four R-type ops that run on the iterative datapath
    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_MULTU) ||
               (funct == F_DIV)  || (funct == F_DIVU);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - one-bit-per-cycle shift-add multiplier / restoring divider with sign fix-up
module iter_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              is_div,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              last,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]    cnt;
    logic                div_mode;
    logic                neg_q;
    logic                neg_r;
    logic                div_zero;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   shreg;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] product_fix;

    // Work on magnitudes; signs are reapplied once all bits are done.
    assign a_neg = is_signed & src1[DATA_W-1];
    assign b_neg = is_signed & src2[DATA_W-1];
    assign last  = (cnt == CNT_W'(DATA_W - 1));

    // Per-iteration arithmetic for both the multiply and the divide step
    always_comb begin
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc, shreg[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
    end

    // Operand capture on start, then one product/quotient bit per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            mag_b    <= '0;
            acc      <= '0;
            shreg    <= '0;
        end else if (start) begin
            cnt      <= '0;
            div_mode <= is_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (src2 == '0);
            mag_b    <= b_neg ? -src2 : src2;
            acc      <= '0;
            shreg    <= a_neg ? -src1 : src1;
        end else if (step) begin
            if (div_mode) begin
                // No borrow means the shifted remainder covers the divisor.
                if (!div_diff[DATA_W]) begin
                    acc   <= div_diff[DATA_W-1:0];
                    shreg <= {shreg[DATA_W-2:0], 1'b1};
                end else begin
                    acc   <= div_shift[DATA_W-1:0];
                    shreg <= {shreg[DATA_W-2:0], 1'b0};
                end
            end else begin
                acc   <= mul_sum[DATA_W:1];
                shreg <= {mul_sum[0], shreg[DATA_W-1:1]};
            end
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Sign fix-up and divide-by-zero substitution on the finished magnitudes
    always_comb begin
        product     = {acc, shreg};
        product_fix = neg_q ? -product : product;
        res_hi      = product_fix[2*DATA_W-1:DATA_W];
        res_lo      = product_fix[DATA_W-1:0];
        if (div_mode) begin
            // Remainder magnitude equals the dividend magnitude when dividing by zero,
            // so the same negation restores the original dividend.
            res_hi = neg_r ? -acc : acc;
            if (div_zero) begin
                res_lo = '1;
            end else begin
                res_lo = neg_q ? -shreg : shreg;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// rtl/alu_ctrl_mc.sv - ALU control decode with multi-cycle mult/div sequencing and HI/LO registers
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        ALUOp_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic              hilo_sel_o,
    output logic [DATA_W-1:0] hilo_val_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    state_t            state;
    logic [3:0]        ctrl;
    logic              illegal;
    logic              hilo_sel;
    logic              md_op;
    logic              accept;
    logic              md_last;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // Combinational decode of ALUOp/funct; every unmapped pair is flagged illegal
    always_comb begin
        ctrl     = CTRL_ILLEGAL;
        illegal  = 1'b1;
        hilo_sel = 1'b0;
        md_op    = 1'b0;
        case (ALUOp_i)
            ALUOP_RTYPE: begin
                illegal = 1'b0;
                case (funct_i)
                    F_SRA:  ctrl = CTRL_SRA;
                    F_SRAV: ctrl = CTRL_SRAV;
                    F_ADD:  ctrl = CTRL_ADD;
                    F_SUB:  ctrl = CTRL_SUB;
                    F_AND:  ctrl = CTRL_AND;
                    F_OR:   ctrl = CTRL_OR;
                    F_SLT:  ctrl = CTRL_SLT;
                    F_MFHI, F_MFLO: begin
                        ctrl     = CTRL_HILO;
                        hilo_sel = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        ctrl  = CTRL_HILO;
                        md_op = 1'b1;
                    end
                    default: begin
                        ctrl    = CTRL_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALUOP_CLS1: begin ctrl = CTRL_CLS1; illegal = 1'b0; end
            ALUOP_CLS2: begin ctrl = CTRL_CLS2; illegal = 1'b0; end
            ALUOP_CLS3: begin ctrl = CTRL_ADD;  illegal = 1'b0; end
            ALUOP_CLS4: begin ctrl = CTRL_CLS4; illegal = 1'b0; end
            ALUOP_CLS5: begin ctrl = CTRL_OR;   illegal = 1'b0; end
            ALUOP_CLS6: begin ctrl = CTRL_CLS6; illegal = 1'b0; end
            default: begin
                ctrl    = CTRL_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

    // Reset masks accept so stall drops the instant reset is asserted.
    assign accept     = !rst_i && valid_i && md_op && is_muldiv(funct_i) && (state == ST_IDLE);
    assign stall_o    = accept || (state != ST_IDLE);
    assign ALUCtrl_o  = CTRL_W'(ctrl);
    assign illegal_o  = illegal;
    assign hilo_sel_o = hilo_sel;
    assign hilo_val_o = hilo_sel ? ((funct_i == F_MFLO) ? lo_q : hi_q) : '0;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    // Sequencer: accept in IDLE, DATA_W iterations in RUN, one fix-up cycle in FIX
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= ST_RUN;
                ST_RUN:  if (md_last) state <= ST_FIX;
                ST_FIX:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // HI/LO commit only on leaving FIX, so an aborted op never touches them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == ST_FIX) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end
    end

    iter_muldiv #(
        .DATA_W (DATA_W)
    ) u_iter_muldiv (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (accept),
        .step      (state == ST_RUN),
        .is_div    (funct_i[1]),
        .is_signed (!funct_i[0]),
        .src1      (src1_i),
        .src2      (src2_i),
        .last      (md_last),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

endmodule
